uart_rx_os16: RTL and testbench
===============================

Name: uart_rx_os16

Overview:
- Serial receive stage that consumes the divider's output `y`.
- The divider runs at k=100 from the 15.36 MHz system clock, giving a 153.6 kHz square wave, which is 16× oversampling for 9600 baud.
- The block samples an asynchronous `rxd` line, assembles 8N1 frames LSB-first, and presents each byte on a valid/ready output port.
- It never uses the divided signal as a clock. Its rising edges are converted into single-cycle tick enables in the `clk` domain.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first.
- OS, 16: ticks per bit. The mid-bit sample point is at OS/2-1 for the start bit and OS-1 thereafter.
- CNT_W, 4: width of the tick counter. Must satisfy 2^CNT_W >= OS.

Ports:
- clk  in  1  system clock (15.36 MHz)
- rstn  in  1  asynchronous active-low reset
- baud16  in  1  divider output square wave; 16× bit rate
- rxd  in  1  asynchronous serial input; idles high
- dout  out  DATA_BITS  received byte; stable while dvalid=1
- dvalid  out  1  byte available
- dready  in  1  consumer accepts dout when dvalid&dready at a clk edge
- frame_err  out  1  one-cycle pulse: stop bit sampled 0, byte discarded
- overrun  out  1  one-cycle pulse: new byte completed while previous not accepted, new byte dropped

Behaviour:
- Interface: one clock `clk`. Reset `rstn` is asynchronous, active-low. All flops clear on `negedge rstn`.
- Reset values:
  - dout=0, dvalid=0, frame_err=0, overrun=0.
  - State=IDLE, counter=0, bit index=0, shift register=0.
  - rxd synchronizer flops=1.
  - baud16 delay flops=0.
- Input synchronization:
  - `rxd` passes through a 2-flop synchronizer to produce `rxd_s`.
  - `baud16` passes through 2 flops plus 1 delay flop. `tick` = synced & ~delayed, a 1-cycle pulse per rising edge.
- If `baud16` is held constant (divider k=0 or in reset), no ticks occur. The FSM holds its state indefinitely and produces no spurious output.
- FSM actions (all on `tick` only, except where noted):
  - IDLE: if rxd_s==0, go to START with cnt=0.
  - START:
    - If cnt==OS/2-1 (7): if rxd_s==0, go to DATA with cnt=0 and bit=0. Otherwise this is a false start; return to IDLE.
    - Otherwise cnt++.
  - DATA:
    - If cnt==OS-1: shift rxd_s into the MSB of the shift register (right shift, so LSB arrives first), cnt=0, bit++.
    - If the shifted bit was bit==DATA_BITS-1, go to STOP.
    - Otherwise cnt++.
  - STOP: if cnt==OS-1, sample rxd_s and go to IDLE with cnt=0. Otherwise cnt++.
    - rxd_s==1: the frame is complete.
    - rxd_s==0: pulse frame_err for 1 clk and discard the byte.
- Returning to IDLE at mid-stop allows back-to-back frames with 1 stop bit.
- Output buffer, evaluated in the clk cycle after the completing tick edge:
  - dvalid=0: dout<=byte, dvalid<=1.
  - dvalid=1 and dready=1 in the same cycle: the old byte is accepted and the new byte loads. dvalid stays 1 and there is no overrun.
  - dvalid=1 and dready=0: keep the old byte, pulse overrun for 1 clk, drop the new byte.
  - Otherwise: dvalid&dready clears dvalid next edge.
- dout changes only on load.
- frame_err and overrun are never asserted simultaneously. A frame error never loads dout.
- Latency: dvalid rises 1 clk after the tick at the stop-bit sample point. Relative to the baud16 rising edge this is 4 clk (2 sync + 1 edge + 1 load).
- Reset mid-frame: all state is cleared immediately. The remainder of the partial frame is then seen from IDLE. Low data bits may be taken as a start bit; that byte is undefined, but the FSM must resynchronize after the next idle-high period of at least 1 bit.
- A glitch low shorter than 8 ticks returns to IDLE with no output and no error.

Test Plan:
- Setup: clk 15.36 MHz; baud16 from the divider with k=100; 1 bit = 1600 clk.
- Single frame: send 0x55 8N1, dready=1 -> dout=0x55; dvalid high exactly 1 cycle, about 9.5 bit times after the start edge; frame_err=overrun=0.
- Back-to-back frames: send 0xA3 then 0x0F, 1 stop bit each, dready held 0 until after the first byte -> dout=0xA3 with dvalid; on the second completion overrun pulses 1 clk and dout stays 0xA3. Then assert dready -> dvalid=0.
- Framing error: send 0xFF with the stop bit forced 0 -> frame_err 1-cycle pulse; dvalid stays 0; the next valid frame 0x3C is received correctly.
- False start: rxd low for 4 ticks (400 clk) then high -> no dvalid, no frame_err, state back to IDLE; the following frame 0x81 is received as 0x81.
- Reset and stall:
  - Assert rstn=0 during bit 3 of 0x96 -> all outputs 0 asynchronously.
  - After release, with the line idle high for 2 bit times, the next frame 0x96 is received correctly.
  - With baud16 held at 0 (k=0), a frame on rxd produces no output.

Source files
------------

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 serial receiver oversampling on ticks derived from a 16x baud square wave
module uart_rx_os16 #(
    parameter int DATA_BITS = 8,
    parameter int OS        = 16,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 baud16,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dvalid,
    input  logic                 dready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int BIT_W = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 rxd_m, rxd_s;
    logic                 b_m, b_s, b_d;
    logic                 done_q, done_d, ferr_q, ferr_d;
    logic                 tick;

    // The divided clock is only ever sampled; each rising edge becomes a one-cycle enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            b_m   <= 1'b0;
            b_s   <= 1'b0;
            b_d   <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            b_m   <= baud16;
            b_s   <= b_m;
            b_d   <= b_s;
        end
    end

    assign tick = b_s & ~b_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        state_d = rxd_s ? IDLE : DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        sh_d    = {rxd_s, sh_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = (bit_q == BIT_LAST) ? STOP : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = rxd_s;
                        ferr_d  = ~rxd_s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout      <= '0;
            dvalid    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_q;
            overrun   <= done_q & dvalid & ~dready;
            if (done_q && (!dvalid || dready)) begin
                dout   <= sh_q;
                dvalid <= 1'b1;
            end else if (dvalid && dready) begin
                dvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed frames with a queue scoreboard checked by an output monitor
module tb_uart_rx_os16;
    localparam int BIT = 160;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       baud16 = 1'b0;
    logic       rxd = 1'b1;
    logic       dready = 1'b0;
    logic       en = 1'b1;
    logic       ignore = 1'b0;
    logic [7:0] dout;
    logic       dvalid, frame_err, overrun;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   width = 0;
    int   last_width = 0;
    int   start_cyc = 0;
    int   events = 0;
    int   ev0 = 0;
    int   lat = 0;
    logic pv = 1'b0;
    ev_t  q[$];

    uart_rx_os16 dut (
        .clk(clk),
        .rstn(rstn),
        .baud16(baud16),
        .rxd(rxd),
        .dout(dout),
        .dvalid(dvalid),
        .dready(dready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // 16x baud square wave: period 10 clk, so one bit is 160 clk
    initial forever begin
        repeat (5) @(negedge clk);
        baud16 = en ? ~baud16 : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic got(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        events++;
        if (!ignore) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
            end else begin
                e = q.pop_front();
                chk("event_kind", 32'(kind), 32'(e.kind));
                if (kind != 2'd1) chk("event_data", 32'(data), 32'(e.data));
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rstn) begin
            if (dvalid && !pv) begin
                rise_cyc = cyc;
                width = 0;
                got(2'd0, dout);
            end
            if (dvalid) width++;
            else if (pv) last_width = width;
            if (frame_err) got(2'd1, dout);
            if (overrun) got(2'd2, dout);
            if (frame_err || overrun) chk("ferr_ovr_exclusive", 32'(frame_err & overrun), 32'd0);
            pv = dvalid;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
        @(negedge clk);
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (i == rst_bit) begin
                repeat (80) @(negedge clk);
                #2 rstn = 1'b0;
                #1;
                chk("async_rst_dout", 32'(dout), 32'd0);
                chk("async_rst_dvalid", 32'(dvalid), 32'd0);
                chk("async_rst_frame_err", 32'(frame_err), 32'd0);
                chk("async_rst_overrun", 32'(overrun), 32'd0);
                repeat (20) @(negedge clk);
                rstn = 1'b1;
                repeat (BIT - 100) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rxd = stop;
        if (stop) begin
            repeat (BIT) @(negedge clk);
        end else begin
            repeat (BIT / 2 + 30) @(negedge clk);
            rxd = 1'b1;
            repeat (BIT / 2 - 30) @(negedge clk);
        end
    endtask

    initial begin
        repeat (20) @(negedge clk);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_dvalid", 32'(dvalid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rstn = 1'b1;
        idle(2);

        dready = 1'b1;
        expect_ev(2'd0, 8'h55);
        send_frame(8'h55, 1'b1, -1);
        idle(1);
        lat = rise_cyc - start_cyc;
        checks++;
        if (lat < 1515 || lat > 1540) begin
            failures++;
            $display("FAIL latency_55: got %0d clk expected 1515..1540", lat);
        end
        chk("dvalid_width_55", 32'(last_width), 32'd1);

        dready = 1'b0;
        expect_ev(2'd0, 8'hA3);
        expect_ev(2'd2, 8'hA3);
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        idle(1);
        chk("b2b_dout", 32'(dout), 32'hA3);
        chk("b2b_dvalid", 32'(dvalid), 32'd1);
        dready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_drain", 32'(dvalid), 32'd0);

        expect_ev(2'd1, 8'h00);
        send_frame(8'hFF, 1'b0, -1);
        idle(2);
        chk("ferr_no_valid", 32'(dvalid), 32'd0);
        expect_ev(2'd0, 8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        idle(1);
        chk("after_ferr_dout", 32'(dout), 32'h3C);

        ev0 = events;
        @(negedge clk);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        idle(2);
        chk("false_start_silent", 32'(events), 32'(ev0));
        dready = 1'b0;
        expect_ev(2'd0, 8'h81);
        send_frame(8'h81, 1'b1, -1);
        idle(1);
        chk("after_false_dvalid", 32'(dvalid), 32'd1);
        chk("after_false_dout", 32'(dout), 32'h81);

        ignore = 1'b1;
        send_frame(8'h96, 1'b1, 3);
        idle(6);
        dready = 1'b1;
        repeat (5) @(negedge clk);
        ignore = 1'b0;
        expect_ev(2'd0, 8'h96);
        send_frame(8'h96, 1'b1, -1);
        idle(1);
        chk("after_reset_dout", 32'(dout), 32'h96);

        en = 1'b0;
        repeat (20) @(negedge clk);
        ev0 = events;
        send_frame(8'h5A, 1'b1, -1);
        idle(2);
        chk("stall_silent", 32'(events), 32'(ev0));
        chk("stall_dvalid", 32'(dvalid), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
